// File: rtl/fifo_read_ctrl.sv
// Read-side FIFO controller: owns the read pointer, issues 1-cycle-latency RAM
// reads and prefetches the head word into a 2-entry output stage (buf0 + skid buf1).
module fifo_read_ctrl #(
    parameter int SIZE     = 4,
    parameter int WIDTH    = 8,
    parameter int AE_LEVEL = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SIZE:0]    w_pointer,
    input  logic             rd_ready,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_ren,
    output logic [SIZE-1:0]  mem_raddr,
    output logic [SIZE:0]    r_pointer,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             empty,
    output logic             a_empty,
    output logic             underflow
);

    logic             r_b0_v;
    logic [WIDTH-1:0] r_b0_d;
    logic             r_b1_v;
    logic [WIDTH-1:0] r_b1_d;
    logic             r_inflight;

    logic [SIZE:0]    w_mem_count;
    logic [1:0]       w_occ;
    logic             w_pop;
    logic [2:0]       w_hold;
    logic [SIZE+1:0]  w_total;

    logic             w_b0_v_n;
    logic [WIDTH-1:0] w_b0_d_n;
    logic             w_b1_v_n;
    logic [WIDTH-1:0] w_b1_d_n;

    assign w_mem_count = w_pointer - r_pointer;
    assign w_occ       = {1'b0, r_b0_v} + {1'b0, r_b1_v};
    assign w_pop       = rd_ready & r_b0_v;
    // Entries still committed after this cycle's pop; pop implies occ >= 1, so no underflow.
    assign w_hold      = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_total     = {1'b0, w_mem_count} + {{SIZE{1'b0}}, w_occ} + {{(SIZE+1){1'b0}}, r_inflight};

    assign mem_ren    = ~reset & (w_mem_count != '0) & (w_hold < 3'd2);
    assign mem_raddr  = r_pointer[SIZE-1:0];
    assign a_empty    = reset | (w_total <= (SIZE+2)'(AE_LEVEL));
    assign dout       = r_b0_d;
    assign dout_valid = r_b0_v;
    assign empty      = ~r_b0_v;

    // Pop first, then place returning data into the first free slot to keep FIFO order.
    always_comb begin
        w_b0_v_n = r_b0_v;
        w_b0_d_n = r_b0_d;
        w_b1_v_n = r_b1_v;
        w_b1_d_n = r_b1_d;
        if (w_pop) begin
            if (r_b1_v) begin
                w_b0_d_n = r_b1_d;
                w_b1_v_n = 1'b0;
            end else begin
                w_b0_v_n = 1'b0;
            end
        end
        if (r_inflight) begin
            if (!w_b0_v_n) begin
                w_b0_v_n = 1'b1;
                w_b0_d_n = mem_rdata;
            end else begin
                w_b1_v_n = 1'b1;
                w_b1_d_n = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pointer  <= '0;
            r_b0_v     <= 1'b0;
            r_b0_d     <= '0;
            r_b1_v     <= 1'b0;
            r_b1_d     <= '0;
            r_inflight <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (mem_ren) begin
                r_pointer <= r_pointer + 1'b1;
            end
            r_inflight <= mem_ren;
            r_b0_v     <= w_b0_v_n;
            r_b0_d     <= w_b0_d_n;
            r_b1_v     <= w_b1_v_n;
            r_b1_d     <= w_b1_d_n;
            underflow  <= rd_ready & ~r_b0_v;
        end
    end

endmodule
